// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scan-out reader.
// Holds the controller state encoding, the fixed pixel packing (four
// 8-bit pixels per 32-bit memory word) and the default frame geometry
// (160x200 pixels at 8 bpp = 8000 words, 40 words per line).
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 8;
    localparam int SEL_W        = $clog2(PIX_PER_WORD);

    localparam int DEF_ADDR_W      = 13;
    localparam int DEF_DATA_W      = PIX_PER_WORD * PIX_W;
    localparam int DEF_FRAME_WORDS = 8000;
    localparam int DEF_LINE_WORDS  = 40;
    localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous show-ahead word FIFO.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears pointers/count)
//   push, push_data - write a word; accepted when not full or when popping
//   pop             - remove the head word; ignored when empty
//   head            - current head word, valid whenever empty is low
//   full, empty     - occupancy flags
//   count           - number of stored words (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_word_fifo
    import fb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // At full, a same-cycle pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scan-out reader: Avalon-MM read master plus pixel streamer.
// Sweeps word addresses 0..FRAME_WORDS-1 once per frame against a memory
// with fixed 1-cycle read latency, buffers words in a small FIFO and
// unpacks each word into four pixels, byte 0 first.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   enable              - start a frame from IDLE; a started frame always completes
//   mem_address, mem_chipselect, mem_write, mem_byteenable
//                       - registered read-master outputs (write tied low, all bytes)
//   mem_readdata        - read data, valid the cycle after chipselect
//   pix_data/pix_valid/pix_ready - pixel stream
//   pix_sof, pix_eol    - first pixel of frame / last pixel of line, qualified by pix_valid
//   frame_done          - pulses in the cycle the last pixel of a frame is accepted
//   busy                - controller is not IDLE
// Stream handshake: a pixel transfers in a cycle where pix_valid and
// pix_ready are both high; while pix_valid is high and pix_ready low, the
// pixel and its markers are held unchanged.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_WORDS - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(PIX_PER_WORD - 1);

    fb_state_t         state;
    fb_state_t         state_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] addr_d;
    logic              cs_d;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    pending;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] out_word;
    logic [COL_W-1:0]  out_col;
    logic              accept;
    logic              word_done;
    logic              last_pix;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign busy           = (state != IDLE);

    // Words already committed to the FIFO: stored, returning this cycle
    // (inflight) and requested this cycle (chipselect). Issuing only while
    // this is below the depth keeps the FIFO from overflowing without
    // looking at pix_ready, so the mem_* registers see no stream path.
    assign pending = {1'b0, fifo_count}
                   + (CNT_W + 1)'(inflight)
                   + (CNT_W + 1)'(mem_chipselect);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rd_addr        <= '0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            inflight       <= 1'b0;
        end else begin
            state          <= state_d;
            rd_addr        <= rd_addr_d;
            mem_address    <= addr_d;
            mem_chipselect <= cs_d;
            inflight       <= mem_chipselect;
        end
    end

    always_comb begin
        state_d   = state;
        rd_addr_d = rd_addr;
        addr_d    = mem_address;
        cs_d      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_d   = RUN;
                    rd_addr_d = '0;
                end
            end
            RUN: begin
                if (!fifo_full && (pending < (CNT_W + 1)'(FIFO_DEPTH))) begin
                    cs_d      = 1'b1;
                    addr_d    = rd_addr;
                    rd_addr_d = rd_addr + ADDR_W'(1);
                    if (rd_addr == LAST_WORD) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pix) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    fb_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_readdata),
        .pop       (word_done),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pix_valid  = !fifo_empty;
    assign accept     = pix_valid && pix_ready;
    assign word_done  = accept && (sel == LAST_SEL);
    assign last_pix   = word_done && (out_word == LAST_WORD);
    assign pix_data   = head[int'(sel) * PIX_W +: PIX_W];
    assign pix_sof    = pix_valid && (out_word == '0) && (sel == '0);
    assign pix_eol    = pix_valid && (out_col == LAST_COL) && (sel == LAST_SEL);
    assign frame_done = last_pix;

    // Output-side position: byte within word, word within line and frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            out_col  <= '0;
            out_word <= '0;
        end else if (accept) begin
            sel <= sel + SEL_W'(1);
            if (sel == LAST_SEL) begin
                out_col  <= (out_col == LAST_COL)   ? '0 : out_col + COL_W'(1);
                out_word <= (out_word == LAST_WORD) ? '0 : out_word + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Testbench for fb_scanout_reader with a small 8-word frame (2 words per line).
module tb_fb_scanout_reader;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = 8;
    localparam int LINE_WORDS  = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int FRAME_PIX   = FRAME_WORDS * 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              enable = 1'b0;
    logic              pix_ready = 1'b0;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_eol;
    logic              frame_done;
    logic              busy;

    fb_scanout_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FRAME_WORDS (FRAME_WORDS),
        .LINE_WORDS  (LINE_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    // Memory: word a holds bytes a, a+1, a+2, a+3 (byte 0 lowest), 1-cycle latency.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= {4{mem_address[7:0]}} + 32'h0302_0100;
    end

    // ---------------- scoreboard state ----------------
    // Entries are {frame_done, eol, sof, data}.
    logic [10:0]       exp_q[$];
    logic [10:0]       obs_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int acc_n, issued, popped, fd_n, stall_cs, stable_err, occ_err, tail_cs, tail_valid;
    bit run_done;
    logic tail_busy;

    // Reference stream: pixel k of a frame is byte (k%4) of word (k/4).
    task automatic build_expected(input int frames);
        exp_q.delete();
        for (int k = 0; k < frames * FRAME_PIX; k++) begin
            int w;
            int b;
            logic [7:0] d;
            w = (k / 4) % FRAME_WORDS;
            b = k % 4;
            d = 8'(w + b);
            exp_q.push_back({(w == FRAME_WORDS - 1 && b == 3),
                             (w % LINE_WORDS == LINE_WORDS - 1 && b == 3),
                             (w == 0 && b == 0), d});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic kick;
        @(negedge clk);
        enable    = 1'b1;
        pix_ready = 1'b0;
    endtask

    // Drives pix_ready/enable each cycle and records what the DUT does,
    // until stop_frames frame_done pulses, then 20 idle cycles.
    task automatic run(input int max_cycles, input int ready_pct, input int stall_cycles,
                       input int drop_at, input int stop_frames);
        logic       prev_stall;
        logic [9:0] prev_out;
        obs_q.delete();
        addr_q.delete();
        acc_n = 0; issued = 0; popped = 0; fd_n = 0; stall_cs = 0;
        stable_err = 0; occ_err = 0; run_done = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        for (int cyc = 0; cyc < max_cycles && !run_done; cyc++) begin
            @(negedge clk);
            pix_ready = (cyc >= stall_cycles) && (int'($urandom_range(99)) < ready_pct);
            if (acc_n >= drop_at) enable = 1'b0;
            #1;
            if (mem_chipselect) begin
                addr_q.push_back(mem_address);
                issued++;
                if (cyc < stall_cycles) stall_cs++;
            end
            if (issued - popped > FIFO_DEPTH) occ_err++;
            if (prev_stall && (!pix_valid || {pix_eol, pix_sof, pix_data} != prev_out)) stable_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_out = {pix_eol, pix_sof, pix_data};
            if (frame_done) fd_n++;
            if (pix_valid && pix_ready) begin
                obs_q.push_back({frame_done, pix_eol, pix_sof, pix_data});
                acc_n++;
                if (acc_n % 4 == 0) popped++;
            end
            if (fd_n >= stop_frames) run_done = 1;
        end
        tail_cs = 0;
        tail_valid = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            pix_ready = 1'b1;
            #1;
            if (mem_chipselect) tail_cs++;
            if (pix_valid) tail_valid++;
        end
        tail_busy = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({mem_chipselect, pix_valid, pix_sof, pix_eol, frame_done, busy, mem_write} !== 7'b0)
            $display("FAIL reset_outputs: got cs,v,sof,eol,fd,busy,wr=%b want 0000000",
                     {mem_chipselect, pix_valid, pix_sof, pix_eol, frame_done, busy, mem_write});
        else n_pass++;
        n_checks++;
        if (mem_address !== '0) $display("FAIL reset_address: got %0d want 0", mem_address);
        else n_pass++;
        n_checks++;
        if (mem_byteenable !== 4'hF) $display("FAIL byteenable: got %h want f", mem_byteenable);
        else n_pass++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || mem_chipselect !== 1'b0)
            $display("FAIL idle_no_enable: got busy=%b cs=%b want 0 0", busy, mem_chipselect);
        else n_pass++;
    endtask

    task automatic test_single_frame;
        kick();
        run(2000, 100, 0, 0, 1);
        build_expected(1);
        n_checks++;
        if (!run_done) $display("FAIL single_timeout: got %0d frame_done want 1", fd_n); else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL single_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL single_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (addr_q.size() != FRAME_WORDS)
            $display("FAIL single_reads: got %0d chipselects want %0d", addr_q.size(), FRAME_WORDS);
        else n_pass++;
        for (int i = 0; i < addr_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== ADDR_W'(i % FRAME_WORDS))
                $display("FAIL single_addr[%0d]: got %0d want %0d", i, addr_q[i], i % FRAME_WORDS);
            else n_pass++;
        end
        n_checks++;
        if (fd_n != 1 || tail_cs != 0 || tail_busy !== 1'b0)
            $display("FAIL single_end: got fd=%0d tail_cs=%0d busy=%b want 1 0 0", fd_n, tail_cs, tail_busy);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        kick();
        run(4000, 30, 0, 0, 1);
        build_expected(1);
        n_checks++;
        if (obs_q.size() != exp_q.size() || !run_done)
            $display("FAIL bp_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL bp_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (stable_err != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_err);
        else n_pass++;
        n_checks++;
        if (occ_err != 0) $display("FAIL bp_credit: got %0d cycles above depth want 0", occ_err);
        else n_pass++;
        n_checks++;
        if (addr_q.size() != FRAME_WORDS)
            $display("FAIL bp_reads: got %0d want %0d", addr_q.size(), FRAME_WORDS);
        else n_pass++;
    endtask

    task automatic test_stall;
        kick();
        run(2000, 100, 50, 0, 1);
        build_expected(1);
        n_checks++;
        if (stall_cs != FIFO_DEPTH)
            $display("FAIL stall_reads: got %0d reads while stalled want %0d", stall_cs, FIFO_DEPTH);
        else n_pass++;
        n_checks++;
        if (stable_err != 0 || occ_err != 0)
            $display("FAIL stall_hold: got stable_err=%0d occ_err=%0d want 0 0", stable_err, occ_err);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size() || !run_done)
            $display("FAIL stall_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL stall_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_multi_frame;
        kick();
        // enable stays high through two frame boundaries, drops inside frame 3
        run(6000, 60, 0, 2 * FRAME_PIX + 5, 3);
        build_expected(3);
        n_checks++;
        if (fd_n != 3 || !run_done) $display("FAIL multi_frames: got %0d frame_done want 3", fd_n);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL multi_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL multi_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (addr_q.size() != 3 * FRAME_WORDS)
            $display("FAIL multi_reads: got %0d want %0d", addr_q.size(), 3 * FRAME_WORDS);
        else n_pass++;
        for (int i = 0; i < addr_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== ADDR_W'(i % FRAME_WORDS))
                $display("FAIL multi_addr[%0d]: got %0d want %0d", i, addr_q[i], i % FRAME_WORDS);
            else n_pass++;
        end
        n_checks++;
        if (tail_cs != 0 || tail_busy !== 1'b0)
            $display("FAIL multi_end: got tail_cs=%0d busy=%b want 0 0", tail_cs, tail_busy);
        else n_pass++;
    endtask

    task automatic test_enable_drop;
        kick();
        run(2000, 100, 0, 5, 1);
        build_expected(1);
        n_checks++;
        if (obs_q.size() != exp_q.size() || !run_done)
            $display("FAIL drop_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL drop_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (tail_cs != 0 || tail_valid != 0 || tail_busy !== 1'b0)
            $display("FAIL drop_idle: got tail_cs=%0d tail_valid=%0d busy=%b want 0 0 0",
                     tail_cs, tail_valid, tail_busy);
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        bit found;
        kick();
        pix_ready = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(negedge clk);
            #1;
            if (mem_chipselect && mem_address == ADDR_W'(3)) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL rst_find_addr3: got no read of address 3 want one"); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({mem_chipselect, pix_valid, pix_sof, pix_eol, frame_done, busy} !== 6'b0 || mem_address !== '0)
            $display("FAIL rst_midframe: got cs,v,sof,eol,fd,busy=%b addr=%0d want 000000 0",
                     {mem_chipselect, pix_valid, pix_sof, pix_eol, frame_done, busy}, mem_address);
        else n_pass++;
        reset = 1'b0;
        run(2000, 100, 0, 0, 1);
        build_expected(1);
        n_checks++;
        if (obs_q.size() != exp_q.size() || !run_done)
            $display("FAIL rst_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL rst_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (addr_q.size() == 0 || addr_q[0] !== '0)
            $display("FAIL rst_restart_addr: got %0d reads first=%0d want first 0",
                     addr_q.size(), (addr_q.size() > 0) ? int'(addr_q[0]) : -1);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_stall();
        test_multi_frame();
        test_enable_drop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
